onehot_scan_encoder: RTL and testbench
======================================

Name: onehot_scan_encoder

Overview:
- Inverse of the register-index decoder: accepts a 32-bit one-hot or multi-hot mask and returns the 5-bit index of each set bit, one per handshake.
- Sits between writeback/scoreboard logic and the register file.
- Serialises multi-bit clear/commit masks into individual register indices.
- Uses valid/ready on both sides.

Parameters:
- WIDTH, 32, mask width; must be a power of two, at least 2.
- IDXW, 5, index width; must equal log2(WIDTH).
- MSB_FIRST, 0, scan order: 0 emits the lowest set bit first, 1 emits the highest set bit first.

Ports:
- CLK  input  1  rising-edge clock.
- RESET_N  input  1  asynchronous active-low reset.
- IN_VALID  input  1  IN_MASK is valid.
- IN_READY  output  1  block can accept a mask.
- IN_MASK  input  WIDTH  request mask; any number of bits may be set.
- OUT_VALID  output  1  OUT_IDX is valid.
- OUT_READY  input  1  consumer accepts OUT_IDX.
- OUT_IDX  output  IDXW  encoded index of the current set bit.
- OUT_LAST  output  1  the current index is the final bit of the mask.
- REMAIN  output  IDXW+1  count of set bits still pending, including the current one.
- ZERO_MASK  output  1  one-cycle pulse: an all-zero mask was accepted.

Behaviour:
- Reset (async assert, sync deassert internally):
  - state = IDLE, pending = 0.
  - OUT_VALID = 0, OUT_IDX = 0, OUT_LAST = 0, REMAIN = 0, ZERO_MASK = 0, IN_READY = 1 once reset is released.
- State machine has two states, IDLE and SCAN. IN_READY = (state == IDLE).
- IDLE:
  - On IN_VALID && IN_READY with IN_MASK != 0: pending <= IN_MASK, REMAIN <= popcount(IN_MASK), go to SCAN.
  - On IN_VALID && IN_READY with IN_MASK == 0: stay in IDLE, ZERO_MASK = 1 for exactly the next cycle, no output beat.
- SCAN:
  - OUT_VALID = 1.
  - OUT_IDX = index of the lowest set bit of pending (highest if MSB_FIRST = 1).
  - OUT_LAST = (REMAIN == 1).
  - On OUT_VALID && OUT_READY: clear that bit in pending and decrement REMAIN. If OUT_LAST is set, go to IDLE with pending = 0.
  - While OUT_READY = 0: OUT_IDX, OUT_LAST, REMAIN and OUT_VALID are held stable.
- Latency: a mask accepted at edge N produces its first beat with OUT_VALID = 1 after edge N. One beat per cycle under continuous OUT_READY. A k-bit mask therefore occupies k cycles in SCAN.
- Back-to-back masks: at least one idle cycle between masks, because IN_READY is 0 throughout SCAN. A new mask is accepted at the earliest on the cycle after the last beat.
- IN_MASK is sampled only on the accept edge. Later changes to IN_MASK have no effect.
- OUT_IDX and OUT_LAST are decoded from registered pending state; no combinational path from IN_* to OUT_*.
- OUT_IDX bit ordering: index i corresponds to IN_MASK[i]. A single bit at i always yields OUT_IDX = i, so driving the 5-to-32 decoder with OUT_IDX reproduces the bit.
- REMAIN spans 0 to WIDTH; all-ones gives REMAIN = 32, which needs IDXW+1 bits.
- Reset asserted mid-SCAN: all remaining beats are discarded immediately and outputs take their reset values asynchronously.

Test Plan:
- Single bit: IN_MASK = 0x00000001, OUT_READY = 1 -> one beat OUT_IDX = 0, OUT_LAST = 1, REMAIN = 1; IN_READY returns to 1 on the following cycle.
- Two bits: IN_MASK = 0x80000010, MSB_FIRST = 0 -> beats OUT_IDX = 4 (REMAIN = 2, LAST = 0), then OUT_IDX = 31 (REMAIN = 1, LAST = 1).
- Full mask: IN_MASK = 0xFFFFFFFF -> 32 consecutive beats with OUT_IDX = 0..31 and REMAIN = 32..1. Rerun with MSB_FIRST = 1 -> OUT_IDX = 31..0.
- Backpressure: IN_MASK = 0x00000A00, OUT_READY held 0 for 3 cycles -> OUT_IDX = 9 held stable with OUT_VALID = 1; release -> 9 then 11; IN_READY = 0 throughout.
- Zero mask: IN_MASK = 0 accepted -> ZERO_MASK pulses for 1 cycle, OUT_VALID stays 0, IN_READY stays 1.
- Reset mid-scan: IN_MASK = 0x0000F000, drop RESET_N after 2 beats -> OUT_VALID = 0 and REMAIN = 0 immediately; after release, a new mask 0x00000002 yields a single beat OUT_IDX = 1.

Source files
------------

// File: rtl/onehot_scan_encoder_if.sv
// Handshake bundle for the one-hot scan encoder: mask request side and index beat side.
interface onehot_scan_encoder_if #(
    parameter int WIDTH = 32,
    parameter int IDXW  = 5
);
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] IN_MASK;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [IDXW-1:0]  OUT_IDX;
    logic             OUT_LAST;
    logic [IDXW:0]    REMAIN;
    logic             ZERO_MASK;

    modport master (
        output IN_VALID, IN_MASK, OUT_READY,
        input  IN_READY, OUT_VALID, OUT_IDX, OUT_LAST, REMAIN, ZERO_MASK
    );

    modport slave (
        input  IN_VALID, IN_MASK, OUT_READY,
        output IN_READY, OUT_VALID, OUT_IDX, OUT_LAST, REMAIN, ZERO_MASK
    );
endinterface

// File: rtl/onehot_scan_encoder.sv
// Serialises a multi-hot mask into one index beat per handshake, lowest (or highest) set bit first.
// WIDTH must be a power of two >= 2 and IDXW must equal log2(WIDTH).
module onehot_scan_encoder #(
    parameter int WIDTH     = 32,
    parameter int IDXW      = 5,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    onehot_scan_encoder_if.slave bus,
    output logic                 dbg_state_o
);

    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    state_t           state_q;
    logic [1:0]       rst_sync_q;
    logic             rst_int_n;
    logic [WIDTH-1:0] pending_q;
    logic [WIDTH-1:0] pending_d;
    logic [IDXW:0]    remain_q;
    logic [IDXW-1:0]  idx_q;
    logic             last_q;
    logic             valid_q;
    logic             zero_q;
    logic [IDXW:0]    in_count;

    function automatic logic [IDXW-1:0] scan_idx(input logic [WIDTH-1:0] m);
        logic [IDXW-1:0] r;
        r = '0;
        if (!MSB_FIRST) begin
            for (int i = WIDTH - 1; i >= 0; i--) if (m[i]) r = IDXW'(i);
        end else begin
            for (int i = 0; i < WIDTH; i++) if (m[i]) r = IDXW'(i);
        end
        return r;
    endfunction

    function automatic logic [IDXW:0] popcount(input logic [WIDTH-1:0] m);
        logic [IDXW:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) c = c + (IDXW+1)'(m[i]);
        return c;
    endfunction

    // Reset asserts asynchronously but is released only after two clean clock edges.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

    assign pending_d = pending_q & ~(WIDTH'(1) << idx_q);
    assign in_count  = popcount(bus.IN_MASK);

    // Valid/ready: a transfer happens on a rising edge where both are 1; a
    // producer holding valid keeps its payload stable until that edge.
    always_ff @(posedge CLK or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            remain_q  <= '0;
            idx_q     <= '0;
            last_q    <= 1'b0;
            valid_q   <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            zero_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.IN_VALID) begin
                        if (bus.IN_MASK != '0) begin
                            pending_q <= bus.IN_MASK;
                            remain_q  <= in_count;
                            idx_q     <= scan_idx(bus.IN_MASK);
                            last_q    <= (in_count == (IDXW+1)'(1));
                            valid_q   <= 1'b1;
                            state_q   <= SCAN;
                        end else begin
                            zero_q <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (bus.OUT_READY) begin
                        if (last_q) begin
                            pending_q <= '0;
                            remain_q  <= '0;
                            idx_q     <= '0;
                            last_q    <= 1'b0;
                            valid_q   <= 1'b0;
                            state_q   <= IDLE;
                        end else begin
                            pending_q <= pending_d;
                            remain_q  <= remain_q - (IDXW+1)'(1);
                            idx_q     <= scan_idx(pending_d);
                            last_q    <= (remain_q == (IDXW+1)'(2));
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.IN_READY  = (state_q == IDLE) && rst_int_n;
    assign bus.OUT_VALID = valid_q;
    assign bus.OUT_IDX   = idx_q;
    assign bus.OUT_LAST  = last_q;
    assign bus.REMAIN    = remain_q;
    assign bus.ZERO_MASK = zero_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_onehot_scan_encoder.sv
// Directed bench for onehot_scan_encoder: LSB-first and MSB-first instances side by side.
module tb_onehot_scan_encoder;

    logic clk;
    logic rst_n;
    logic dbg0;
    logic dbg1;
    int   errors;
    int   checks;

    onehot_scan_encoder_if #(.WIDTH(32), .IDXW(5)) bus0 ();
    onehot_scan_encoder_if #(.WIDTH(32), .IDXW(5)) bus1 ();

    onehot_scan_encoder #(.WIDTH(32), .IDXW(5), .MSB_FIRST(1'b0)) dut0 (
        .CLK(clk), .RESET_N(rst_n), .bus(bus0.slave), .dbg_state_o(dbg0)
    );
    onehot_scan_encoder #(.WIDTH(32), .IDXW(5), .MSB_FIRST(1'b1)) dut1 (
        .CLK(clk), .RESET_N(rst_n), .bus(bus1.slave), .dbg_state_o(dbg1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        bus0.IN_VALID = 1'b0; bus0.IN_MASK = '0; bus0.OUT_READY = 1'b1;
        bus1.IN_VALID = 1'b0; bus1.IN_MASK = '0; bus1.OUT_READY = 1'b1;

        // reset values
        cyc(3);
        check("rst_valid", bus0.OUT_VALID, 0);
        check("rst_idx", bus0.OUT_IDX, 0);
        check("rst_last", bus0.OUT_LAST, 0);
        check("rst_remain", bus0.REMAIN, 0);
        check("rst_zero", bus0.ZERO_MASK, 0);
        check("rst_state", dbg0, 0);
        rst_n = 1'b1;
        cyc(3);
        check("rel_in_ready", bus0.IN_READY, 1);

        // single bit
        bus0.IN_VALID = 1'b1; bus0.IN_MASK = 32'h0000_0001;
        cyc(1);
        bus0.IN_VALID = 1'b0;
        check("single_valid", bus0.OUT_VALID, 1);
        check("single_idx", bus0.OUT_IDX, 0);
        check("single_last", bus0.OUT_LAST, 1);
        check("single_remain", bus0.REMAIN, 1);
        check("single_in_ready", bus0.IN_READY, 0);
        cyc(1);
        check("single_done_valid", bus0.OUT_VALID, 0);
        check("single_done_in_ready", bus0.IN_READY, 1);

        // two bits, low first
        bus0.IN_VALID = 1'b1; bus0.IN_MASK = 32'h8000_0010;
        cyc(1);
        bus0.IN_VALID = 1'b0; bus0.IN_MASK = 32'h0000_0004;
        check("two_idx0", bus0.OUT_IDX, 4);
        check("two_remain0", bus0.REMAIN, 2);
        check("two_last0", bus0.OUT_LAST, 0);
        cyc(1);
        check("two_idx1", bus0.OUT_IDX, 31);
        check("two_remain1", bus0.REMAIN, 1);
        check("two_last1", bus0.OUT_LAST, 1);
        cyc(1);
        check("two_done", bus0.OUT_VALID, 0);

        // full mask on both scan orders
        bus0.IN_VALID = 1'b1; bus0.IN_MASK = 32'hFFFF_FFFF;
        bus1.IN_VALID = 1'b1; bus1.IN_MASK = 32'hFFFF_FFFF;
        for (int i = 0; i < 32; i++) begin
            cyc(1);
            bus0.IN_VALID = 1'b0;
            bus1.IN_VALID = 1'b0;
            check($sformatf("full_lsb_idx%0d", i), bus0.OUT_IDX, i);
            check($sformatf("full_lsb_rem%0d", i), bus0.REMAIN, 32 - i);
            check($sformatf("full_lsb_last%0d", i), bus0.OUT_LAST, (i == 31) ? 1 : 0);
            check($sformatf("full_msb_idx%0d", i), bus1.OUT_IDX, 31 - i);
            check($sformatf("full_msb_rem%0d", i), bus1.REMAIN, 32 - i);
            check($sformatf("full_lsb_valid%0d", i), bus0.OUT_VALID, 1);
        end
        cyc(1);
        check("full_lsb_done", bus0.OUT_VALID, 0);
        check("full_msb_done", bus1.OUT_VALID, 0);

        // backpressure
        bus0.OUT_READY = 1'b0;
        bus0.IN_VALID = 1'b1; bus0.IN_MASK = 32'h0000_0A00;
        cyc(1);
        bus0.IN_VALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bp_hold_idx%0d", i), bus0.OUT_IDX, 9);
            check($sformatf("bp_hold_valid%0d", i), bus0.OUT_VALID, 1);
            check($sformatf("bp_hold_remain%0d", i), bus0.REMAIN, 2);
            check($sformatf("bp_hold_in_ready%0d", i), bus0.IN_READY, 0);
            cyc(1);
        end
        bus0.OUT_READY = 1'b1;
        check("bp_rel_idx0", bus0.OUT_IDX, 9);
        cyc(1);
        check("bp_rel_idx1", bus0.OUT_IDX, 11);
        check("bp_rel_last1", bus0.OUT_LAST, 1);
        check("bp_rel_in_ready", bus0.IN_READY, 0);
        cyc(1);
        check("bp_done", bus0.OUT_VALID, 0);

        // zero mask
        bus0.IN_VALID = 1'b1; bus0.IN_MASK = 32'h0;
        cyc(1);
        bus0.IN_VALID = 1'b0;
        check("zero_pulse", bus0.ZERO_MASK, 1);
        check("zero_valid", bus0.OUT_VALID, 0);
        check("zero_in_ready", bus0.IN_READY, 1);
        cyc(1);
        check("zero_pulse_end", bus0.ZERO_MASK, 0);
        check("zero_valid_end", bus0.OUT_VALID, 0);

        // reset mid-scan
        bus0.IN_VALID = 1'b1; bus0.IN_MASK = 32'h0000_F000;
        cyc(1);
        bus0.IN_VALID = 1'b0;
        check("rms_idx0", bus0.OUT_IDX, 12);
        cyc(1);
        check("rms_idx1", bus0.OUT_IDX, 13);
        cyc(1);
        check("rms_idx2", bus0.OUT_IDX, 14);
        rst_n = 1'b0;
        #1;
        check("rms_valid", bus0.OUT_VALID, 0);
        check("rms_remain", bus0.REMAIN, 0);
        check("rms_idx", bus0.OUT_IDX, 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(3);
        check("rms_in_ready", bus0.IN_READY, 1);
        bus0.IN_VALID = 1'b1; bus0.IN_MASK = 32'h0000_0002;
        cyc(1);
        bus0.IN_VALID = 1'b0;
        check("rms_new_idx", bus0.OUT_IDX, 1);
        check("rms_new_last", bus0.OUT_LAST, 1);
        check("rms_new_remain", bus0.REMAIN, 1);
        cyc(1);
        check("rms_new_done", bus0.OUT_VALID, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
